// File: rtl/spi_slave_shifter_pkg.sv
// Shared definitions for the SPI slave shifter: byte width, SPI mode and FSM encodings.
package spi_slave_shifter_pkg;

    localparam int BYTE_W = 8;

    // Mode number is {cpol, cpha}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Modes 0 and 3 sample on the rising SCLK edge; modes 1 and 2 sample on the falling edge.
    function automatic logic sample_on_rise(input spi_mode_e mode);
        return (mode == SPI_MODE0) || (mode == SPI_MODE3);
    endfunction

endpackage

// File: rtl/spi_slave_shifter_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by a delay flop for edge detection.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_idle_level,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   level;

    // Reset to the pin's idle level so that reset release never looks like an edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= {SYNC_STAGES{i_idle_level}};
            dly_q  <= i_idle_level;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign o_rise = level & ~dly_q;
    assign o_fall = ~level & dly_q;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave byte shifter: oversampled SPI pins, one-byte tx holding buffer, rx output register.
//
// state     | meaning
// ST_IDLE   | SS deasserted; SCLK ignored, MISO tri-stated
// ST_ACTIVE | SS asserted; shifting bits on sample/setup edges
module spi_slave_shifter
    import spi_slave_shifter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_sclk,
    input  logic              i_ss_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [BYTE_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [BYTE_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_underrun,
    input  logic              i_flag_clr
);

    spi_state_e          state_q, state_d;
    logic                sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                mosi_s;
    logic                enter, leave;
    logic                sample_edge, setup_edge, do_sample, do_setup;
    logic                tx_load, tx_shift, byte_done;
    logic                push;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-1:0]   rx_shift_q, tx_shift_q, hold_data_q;
    logic [BYTE_W-1:0]   rx_byte;
    logic                hold_full_q;
    spi_mode_e           mode;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_idle_level (i_cpol),
        .i_pin        (i_sclk),
        .o_rise       (sclk_rise),
        .o_fall       (sclk_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_idle_level (1'b1),
        .i_pin        (i_ss_n),
        .o_rise       (ss_rise),
        .o_fall       (ss_fall)
    );

    // Same depth as the SCLK chain so the sampled bit lines up with the detected edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) mosi_q <= '0;
        else            mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        leave   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d = ST_ACTIVE;
                    enter   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    leave   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mode        = spi_mode_e'({i_cpol, i_cpha});
    assign sample_edge = sample_on_rise(mode) ? sclk_rise : sclk_fall;
    assign setup_edge  = sample_on_rise(mode) ? sclk_fall : sclk_rise;
    assign do_sample   = (state_q == ST_ACTIVE) && !ss_rise && sample_edge;
    assign do_setup    = (state_q == ST_ACTIVE) && !ss_rise && setup_edge;
    assign tx_load     = (enter && !i_cpha) || (do_setup && (bit_cnt == 3'd0));
    assign tx_shift    = do_setup && (bit_cnt != 3'd0);
    assign byte_done   = do_sample && (bit_cnt == 3'd7);
    assign rx_byte     = {rx_shift_q[BYTE_W-2:0], mosi_s};
    assign push        = i_tx_valid && !hold_full_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bit_cnt     <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
            o_overrun   <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            if (enter || leave) begin
                bit_cnt    <= '0;
                rx_shift_q <= '0;
            end else if (do_sample) begin
                bit_cnt    <= bit_cnt + 3'd1;
                rx_shift_q <= rx_byte;
            end

            if (leave)         tx_shift_q <= '0;
            else if (tx_load)  tx_shift_q <= hold_full_q ? hold_data_q : 8'hFF;
            else if (tx_shift) tx_shift_q <= {tx_shift_q[BYTE_W-2:0], 1'b0};

            // A push can only land when empty, so a same-cycle pop sees the empty buffer.
            if (push) begin
                hold_full_q <= 1'b1;
                hold_data_q <= i_tx_data;
            end else if (tx_load) begin
                hold_full_q <= 1'b0;
            end

            if (byte_done) begin
                o_rx_data  <= rx_byte;
                o_rx_valid <= 1'b1;
            end else if (i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end

            if (byte_done && o_rx_valid && !i_rx_ready) o_overrun <= 1'b1;
            else if (i_flag_clr)                        o_overrun <= 1'b0;

            if (tx_load && !hold_full_q) o_underrun <= 1'b1;
            else if (i_flag_clr)         o_underrun <= 1'b0;
        end
    end

    assign o_miso     = tx_shift_q[BYTE_W-1];
    assign o_miso_oe  = (state_q == ST_ACTIVE);
    assign o_busy     = (state_q == ST_ACTIVE);
    assign o_tx_ready = !hold_full_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Self-checking bench for spi_slave_shifter: directed cases plus randomized bursts vs a queue model.
module tb_spi_slave_shifter;

    localparam int H = 8;  // SCLK half period in i_clk cycles (SCLK = i_clk/16)

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_cpol = 1'b0, i_cpha = 1'b0;
    logic       i_sclk = 1'b0, i_ss_n = 1'b1, i_mosi = 1'b0;
    logic       o_miso, o_miso_oe;
    logic [7:0] i_tx_data = 8'h00;
    logic       i_tx_valid = 1'b0;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       i_rx_ready = 1'b1;
    logic       o_busy, o_overrun, o_underrun;
    logic       i_flag_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_q[$];     // bytes waiting to be pushed into the DUT
    logic [7:0] tx_list[$];  // bytes the next scenario offers to the DUT
    logic [7:0] m_out[$];    // bytes the master sends
    logic [7:0] m_in[$];     // bytes the master received on MISO
    logic [7:0] rx_got[$];   // bytes handed out on the rx interface
    bit         tx_fire = 1'b0;

    spi_slave_shifter #(.SYNC_STAGES(2)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_cpol     (i_cpol),
        .i_cpha     (i_cpha),
        .i_sclk     (i_sclk),
        .i_ss_n     (i_ss_n),
        .i_mosi     (i_mosi),
        .o_miso     (o_miso),
        .o_miso_oe  (o_miso_oe),
        .i_tx_data  (i_tx_data),
        .i_tx_valid (i_tx_valid),
        .o_tx_ready (o_tx_ready),
        .o_rx_data  (o_rx_data),
        .o_rx_valid (o_rx_valid),
        .i_rx_ready (i_rx_ready),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_underrun (o_underrun),
        .i_flag_clr (i_flag_clr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Producer: the handshake seen at a negedge lands on the following posedge.
    always @(negedge i_clk) begin
        if (tx_fire && tx_q.size() > 0) void'(tx_q.pop_front());
        i_tx_valid = (tx_q.size() > 0);
        i_tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        tx_fire    = i_tx_valid && o_tx_ready && i_reset_n;
    end

    always @(negedge i_clk) begin
        if (i_reset_n && i_rx_ready && o_rx_valid) rx_got.push_back(o_rx_data);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // SPI master: nbits bits of m_out, MSB first, in the current mode; full bytes of MISO go to m_in.
    task automatic spi_xfer(input int nbits);
        logic [7:0] cur;
        cur = 8'h00;
        i_ss_n = 1'b0;
        if (!i_cpha) i_mosi = m_out[0][7];
        wait_clk(H);
        for (int b = 0; b < nbits; b++) begin
            if (i_cpha) begin
                i_sclk = ~i_sclk;
                i_mosi = m_out[b / 8][7 - (b % 8)];
                wait_clk(H);
            end
            cur    = {cur[6:0], o_miso};
            i_sclk = ~i_sclk;
            if (b % 8 == 7) m_in.push_back(cur);
            wait_clk(H);
            if (!i_cpha) begin
                i_sclk = ~i_sclk;
                if (b + 1 < nbits) i_mosi = m_out[(b + 1) / 8][7 - ((b + 1) % 8)];
                wait_clk(H);
            end
        end
        i_ss_n = 1'b1;
        i_mosi = 1'b0;
        wait_clk(3 * H);
    endtask

    task automatic set_mode(input bit cpol, input bit cpha);
        i_cpol = cpol;
        i_cpha = cpha;
        i_sclk = cpol;
        wait_clk(10);
    endtask

    task automatic clear_flags();
        i_flag_clr = 1'b1;
        wait_clk(1);
        i_flag_clr = 1'b0;
        wait_clk(1);
    endtask

    // Model: each load pops the next offered byte, else 0xFF; cpha=0 loads once more at SS assert.
    task automatic run_scenario(input bit cpol, input bit cpha, input string name);
        int n, n_tx, pops;
        set_mode(cpol, cpha);
        n    = m_out.size();
        n_tx = tx_list.size();
        pops = n + (cpha ? 0 : 1);
        m_in.delete();
        rx_got.delete();
        foreach (tx_list[k]) tx_q.push_back(tx_list[k]);
        if (n_tx > 0) begin
            for (int t = 0; t < 50 && o_tx_ready; t++) wait_clk(1);
            chk({name, ":preload"}, o_tx_ready, 1'b0);
        end
        spi_xfer(8 * n);
        chk({name, ":rx_cnt"}, rx_got.size(), n);
        chk({name, ":miso_cnt"}, m_in.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < rx_got.size()) chk({name, ":rx"}, rx_got[k], m_out[k]);
            if (k < m_in.size())   chk({name, ":miso"}, m_in[k], (k < n_tx) ? tx_list[k] : 8'hFF);
        end
        chk({name, ":underrun"}, o_underrun, (pops > n_tx));
        chk({name, ":overrun"}, o_overrun, 1'b0);
        chk({name, ":tx_ready"}, o_tx_ready, 1'b1);
        chk({name, ":idle"}, {o_busy, o_miso_oe}, 2'b00);
        clear_flags();
        chk({name, ":flags_clr"}, {o_overrun, o_underrun}, 2'b00);
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_clk(3);
        chk("rst:outs", {o_miso, o_miso_oe, o_busy, o_rx_valid, o_overrun, o_underrun}, 6'b0);
        chk("rst:tx_ready", o_tx_ready, 1'b1);
        chk("rst:rx_data", o_rx_data, 8'h00);
        i_reset_n = 1'b1;
        wait_clk(5);

        // Mode 0 single byte
        tx_list = '{8'hA5};
        m_out   = '{8'h3C};
        run_scenario(1'b0, 1'b0, "m0_basic");

        // Two-byte burst in every mode
        for (int m = 0; m < 4; m++) begin
            tx_list = '{8'h81, 8'h7E};
            m_out   = '{8'hF0, 8'h0F};
            run_scenario(m[1], m[0], $sformatf("burst_m%0d", m));
        end

        // Nothing offered: MISO shifts 0xFF and underrun stays until cleared
        tx_list.delete();
        m_out = '{8'h5A};
        set_mode(1'b0, 1'b1);
        m_in.delete();
        spi_xfer(8);
        chk("underrun:miso", (m_in.size() > 0) ? m_in[0] : 9'h100, 8'hFF);
        wait_clk(20);
        chk("underrun:sticky", o_underrun, 1'b1);
        clear_flags();
        chk("underrun:clr", o_underrun, 1'b0);

        // Consumer stalled across two bytes
        i_rx_ready = 1'b0;
        m_out = '{8'h11, 8'h22};
        set_mode(1'b0, 1'b0);
        spi_xfer(16);
        chk("overrun:data", o_rx_data, 8'h22);
        chk("overrun:flag", o_overrun, 1'b1);
        chk("overrun:valid", o_rx_valid, 1'b1);
        i_rx_ready = 1'b1;
        wait_clk(4);
        chk("overrun:drained", o_rx_valid, 1'b0);
        clear_flags();
        rx_got.delete();

        // SS dropped after five bits
        m_out = '{8'hC3};
        spi_xfer(5);
        chk("abort:rx_cnt", rx_got.size(), 0);
        chk("abort:valid", o_rx_valid, 1'b0);
        chk("abort:idle", {o_busy, o_miso_oe}, 2'b00);
        clear_flags();
        tx_list = '{8'h96};
        m_out   = '{8'h69};
        run_scenario(1'b0, 1'b0, "abort_next");

        // Randomized bursts in random modes
        for (int it = 0; it < 8; it++) begin
            int mode, n, pops;
            mode = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            pops = n + ((mode % 2) ? 0 : 1);
            m_out.delete();
            tx_list.delete();
            for (int k = 0; k < n; k++) m_out.push_back(8'($urandom));
            for (int k = 0, nt = $urandom_range(0, pops); k < nt; k++) tx_list.push_back(8'($urandom));
            run_scenario(mode[1], mode[0], $sformatf("rand%0d_m%0d", it, mode));
        end

        // Reset in the middle of a byte
        set_mode(1'b0, 1'b0);
        tx_q.push_back(8'hE7);
        wait_clk(10);
        i_ss_n = 1'b0;
        i_mosi = 1'b1;
        wait_clk(H);
        for (int k = 0; k < 6; k++) begin
            i_sclk = ~i_sclk;
            wait_clk(H);
        end
        chk("midrst:active", o_miso_oe, 1'b1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("midrst:oe", o_miso_oe, 1'b0);
        chk("midrst:outs", {o_miso, o_busy, o_rx_valid, o_overrun, o_underrun}, 5'b0);
        chk("midrst:tx_ready", o_tx_ready, 1'b1);
        chk("midrst:rx_data", o_rx_data, 8'h00);
        i_ss_n = 1'b1;
        i_sclk = 1'b0;
        i_mosi = 1'b0;
        wait_clk(3);
        i_reset_n = 1'b1;
        wait_clk(5);
        tx_list = '{8'h3D};
        m_out   = '{8'hB4};
        run_scenario(1'b1, 1'b1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
